ldpc_3gpp_dec_hb_row_ctrl: RTL

LDPC_3GPP_DEC_HB_ROW_CTRL -- requirements
Module: ldpc_3gpp_dec_hb_row_ctrl

---
 rtl/ldpc_3gpp_dec_hb_row_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/ldpc_3gpp_dec_hb_row_ctrl.sv
// Row-group / word sequencer for the 3GPP LDPC decoder Hb table: read stream, delayed write stream, iteration control.
// Optional early termination on syndrome-clear is enabled by defining LDPC_3GPP_DEC_EARLY_STOP_EN.
module ldpc_3gpp_dec_hb_row_ctrl #(
   parameter int pROW_W    = 6,
   parameter int pZC_W     = 9,
   parameter int pITER_W   = 8,
   parameter int pWR_DELAY = 4
) (
   input  logic               iclk,
   input  logic               ireset,
   input  logic               iclkena,
   input  logic               istart,
   input  logic [pITER_W-1:0] iNiter,
   input  logic [pROW_W-1:0]  iused_row,
   input  logic [pZC_W-1:0]   iused_zc,
`ifdef LDPC_3GPP_DEC_EARLY_STOP_EN
   input  logic               isyn_ok,
`endif
   output logic [pROW_W-1:0]  orrow,
   output logic [pROW_W-1:0]  owrow,
   output logic               orval,
   output logic               owval,
   output logic [pZC_W-1:0]   ozcnt,
   output logic [pITER_W-1:0] oiter,
   output logic               obusy,
   output logic               odone
);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

   // all stages except the output one; used to detect that only the last word remains in flight
   localparam logic [pWR_DELAY-1:0] cPEND_MASK = {pWR_DELAY{1'b1}} >> 1;

   state_t               state, state_nxt;

   logic [pITER_W-1:0]   niter;
   logic [pROW_W-1:0]    used_row;
   logic [pZC_W-1:0]     used_zc;
   logic [pITER_W-1:0]   iter_cnt;
   logic [pROW_W-1:0]    row_cnt;
   logic [pZC_W-1:0]     zc_cnt;

   logic [pWR_DELAY-1:0] dl_val;
   logic [pROW_W-1:0]    dl_row [pWR_DELAY];
   logic                 dl_pend;

   logic                 last_word;
   logic                 last_iter;
   logic                 stop_run;

   assign last_word = (zc_cnt == used_zc - 1'b1) && (row_cnt == used_row - 1'b1);
   assign last_iter = (iter_cnt == niter - 1'b1);
`ifdef LDPC_3GPP_DEC_EARLY_STOP_EN
   assign stop_run  = last_iter | isyn_ok;
`else
   assign stop_run  = last_iter;
`endif
   assign dl_pend   = |(dl_val & cPEND_MASK);

   always_ff @(posedge iclk or negedge ireset) begin
      if (!ireset) begin
         state <= IDLE;
      end else if (iclkena) begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE    : if (istart) state_nxt = RUN;
         RUN     : if (last_word && stop_run) state_nxt = FLUSH;
         FLUSH   : if (dl_val[pWR_DELAY-1] && !dl_pend && !orval) state_nxt = DONE;
         DONE    : state_nxt = IDLE;
         default : state_nxt = IDLE;
      endcase
   end

   always_comb begin
      obusy = (state != IDLE);
      odone = (state == DONE);
   end

   always_ff @(posedge iclk or negedge ireset) begin
      if (!ireset) begin
         niter    <= '0;
         used_row <= '0;
         used_zc  <= '0;
         iter_cnt <= '0;
         row_cnt  <= '0;
         zc_cnt   <= '0;
         orval    <= 1'b0;
         orrow    <= '0;
         ozcnt    <= '0;
      end else if (iclkena) begin
         case (state)
            IDLE : begin
               orval <= 1'b0;
               orrow <= '0;
               ozcnt <= '0;
               if (istart) begin
                  // zero-valued table entries are treated as one so every run makes progress
                  niter    <= (iNiter    == '0) ? pITER_W'(1) : iNiter;
                  used_row <= (iused_row == '0) ? pROW_W'(1)  : iused_row;
                  used_zc  <= (iused_zc  == '0) ? pZC_W'(1)   : iused_zc;
                  iter_cnt <= '0;
                  row_cnt  <= '0;
                  zc_cnt   <= '0;
               end
            end
            RUN : begin
               orval <= 1'b1;
               orrow <= row_cnt;
               ozcnt <= zc_cnt;
               if (zc_cnt == used_zc - 1'b1) begin
                  zc_cnt <= '0;
                  if (row_cnt == used_row - 1'b1) begin
                     row_cnt  <= '0;
                     iter_cnt <= iter_cnt + 1'b1;
                  end else begin
                     row_cnt <= row_cnt + 1'b1;
                  end
               end else begin
                  zc_cnt <= zc_cnt + 1'b1;
               end
            end
            default : begin
               orval <= 1'b0;
               orrow <= '0;
               ozcnt <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge iclk or negedge ireset) begin
      if (!ireset) begin
         dl_val <= '0;
         for (int unsigned i = 0; i < pWR_DELAY; i++) begin
            dl_row[i] <= '0;
         end
      end else if (iclkena) begin
         dl_val[0] <= orval;
         dl_row[0] <= orrow;
         for (int unsigned i = 1; i < pWR_DELAY; i++) begin
            dl_val[i] <= dl_val[i-1];
            dl_row[i] <= dl_row[i-1];
         end
      end
   end

   assign owval = dl_val[pWR_DELAY-1];
   assign owrow = dl_row[pWR_DELAY-1];
   assign oiter = iter_cnt;

endmodule
